// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: parametrised fetch/decode/execute instruction pipeline.
// Stage 0 is the fetch stage. Stage k holds the instruction fetched k edges
// earlier. The block handles the bus-request fetch stall, the operand-fetch
// suppress, the branch flush and the global hold.
// Optional statistics counters are enabled by defining PIPE_STATS_EN.
//
// Handshake: the fetch stage offers FetchReq. A byte transfers on a rising
// edge where FetchReq and MemValid are both 1 (PcInc = 1). The memory side
// must not assume the byte was taken unless PcInc was 1. MemData is ignored
// on any other edge.
module pipeline_sequencer #(
  parameter int              DATA_W = 8,
  parameter int              STAGES = 3,
  parameter logic [DATA_W-1:0] NOP  = '0
) (
  input  logic                     ClockIn,
  input  logic                     ResetIn_n,
  input  logic [DATA_W-1:0]        MemData,
  input  logic                     MemValid,
  output logic                     FetchReq,
  output logic                     PcInc,
  input  logic                     BusRequest,
  input  logic                     Suppress,
  input  logic                     Flush,
  input  logic                     HoldIn,
  output logic [STAGES*DATA_W-1:0] StageInstr,
  output logic [STAGES-1:0]        StageValid,
  output logic [DATA_W-1:0]        OperandOut,
  output logic                     OperandValid,
  output logic [15:0]              RetireCount
`ifdef PIPE_STATS_EN
  ,
  output logic [15:0]              BubbleCount,
  output logic [15:0]              HoldCount
`endif
);

  logic [DATA_W-1:0] instr_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic              take_instr;
  logic              take_operand;

  // FetchReq already excludes hold, flush and bus request, so PcInc alone
  // qualifies an accepted byte.
  assign FetchReq     = ResetIn_n & ~HoldIn & ~Flush & ~BusRequest;
  assign PcInc        = FetchReq & MemValid;
  assign take_instr   = PcInc & ~Suppress;
  assign take_operand = PcInc & Suppress;

  // Present the stage registers on the flat output bus, stage k at slice k.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage_out
    assign StageInstr[g*DATA_W +: DATA_W] = instr_q[g];
  end
  assign StageValid = valid_q;

  // Stage registers, operand capture and retire counter.
  always_ff @(posedge ClockIn) begin
    if (!ResetIn_n) begin
      for (int k = 0; k < STAGES; k++) begin
        instr_q[k] <= NOP;
      end
      valid_q      <= '0;
      OperandOut   <= '0;
      OperandValid <= 1'b0;
      RetireCount  <= '0;
    end else if (HoldIn) begin
      OperandValid <= 1'b0;
    end else begin
      if (valid_q[STAGES-1]) begin
        RetireCount <= RetireCount + 16'd1;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (Flush) begin
          instr_q[k] <= NOP;
          valid_q[k] <= 1'b0;
        end else begin
          instr_q[k] <= instr_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
      // Anything other than an accepted instruction byte is a bubble.
      instr_q[0]   <= take_instr ? MemData : NOP;
      valid_q[0]   <= take_instr;
      OperandValid <= take_operand;
      if (take_operand) begin
        OperandOut <= MemData;
      end
    end
  end

`ifdef PIPE_STATS_EN
  // Bubble and hold statistics. Both counters wrap at 16 bits.
  always_ff @(posedge ClockIn) begin
    if (!ResetIn_n) begin
      BubbleCount <= '0;
      HoldCount   <= '0;
    end else if (HoldIn) begin
      HoldCount <= HoldCount + 16'd1;
    end else if (!take_instr) begin
      BubbleCount <= BubbleCount + 16'd1;
    end
  end
`endif

endmodule
